// File: rtl/multi_trigger_logic.sv
// Trigger qualifier: masked AND/OR combine of per-channel flags, consecutive-cycle
// qualification, sticky trigger flag, source latch and saturating event counter.
module multi_trigger_logic #(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned QUAL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic [NUM_CH-1:0] trig_en,
  input  logic              trig_mode,
  input  logic [QUAL_W-1:0] qual_cnt,
  input  logic              armed,
  input  logic              set_capture_done,
  output logic              triggered,
  output logic              qualifying,
  output logic [NUM_CH-1:0] trig_src,
  output logic [CNT_W-1:0]  trig_count
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StQual  = 2'd1,
    StTrigd = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [QUAL_W-1:0] qcnt_q, qcnt_d;
  logic [NUM_CH-1:0] trig_src_q;
  logic [CNT_W-1:0]  trig_count_q;
  logic              cond_and, cond_or, cond, hit;
  logic              trig_load;

  // An empty mask must never satisfy AND mode, hence the explicit |trig_en term.
  assign cond_and = (&(ch_trig | ~trig_en)) & (|trig_en);
  assign cond_or  = |(ch_trig & trig_en);
  assign cond     = trig_mode ? cond_or : cond_and;
  assign hit      = armed & cond;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    trig_load = 1'b0;
    if (set_capture_done) begin
      state_d = StIdle;
      qcnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hit && (qual_cnt == '0)) begin
            state_d   = StTrigd;
            qcnt_d    = '0;
            trig_load = 1'b1;
          end else if (hit) begin
            state_d = StQual;
            qcnt_d  = QUAL_W'(1);
          end else begin
            qcnt_d = '0;
          end
        end
        StQual: begin
          if (!hit) begin
            state_d = StIdle;
            qcnt_d  = '0;
          end else if (qcnt_q >= qual_cnt) begin
            // >= lets a lowered qual_cnt finish qualification on the next edge.
            state_d   = StTrigd;
            qcnt_d    = '0;
            trig_load = 1'b1;
          end else begin
            qcnt_d = qcnt_q + QUAL_W'(1);
          end
        end
        StTrigd: begin
          state_d = StTrigd;
        end
        default: begin
          state_d = StIdle;
          qcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    triggered  = (state_q == StTrigd);
    qualifying = (state_q == StQual);
    trig_src   = trig_src_q;
    trig_count = trig_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_src_q   <= '0;
      trig_count_q <= '0;
    end else if (trig_load) begin
      trig_src_q <= ch_trig & trig_en;
      if (trig_count_q != {CNT_W{1'b1}}) begin
        trig_count_q <= trig_count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_trigger_logic.sv
// Directed bench for multi_trigger_logic; a second instance with a 2-bit counter
// shares the stimulus to exercise counter saturation.
module tb_multi_trigger_logic;

  logic       clk;
  logic       rst_n;
  logic [4:0] ch_trig;
  logic [4:0] trig_en;
  logic       trig_mode;
  logic [7:0] qual_cnt;
  logic       armed;
  logic       set_capture_done;
  logic       triggered, qualifying;
  logic [4:0] trig_src;
  logic [15:0] trig_count;
  logic       sat_triggered, sat_qualifying;
  logic [4:0] sat_trig_src;
  logic [1:0] sat_trig_count;

  int n_checks = 0;
  int n_errors = 0;

  multi_trigger_logic #(.NUM_CH(5), .QUAL_W(8), .CNT_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ch_trig          (ch_trig),
    .trig_en          (trig_en),
    .trig_mode        (trig_mode),
    .qual_cnt         (qual_cnt),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .triggered        (triggered),
    .qualifying       (qualifying),
    .trig_src         (trig_src),
    .trig_count       (trig_count)
  );

  multi_trigger_logic #(.NUM_CH(5), .QUAL_W(8), .CNT_W(2)) dut_sat (
    .clk              (clk),
    .rst_n            (rst_n),
    .ch_trig          (ch_trig),
    .trig_en          (trig_en),
    .trig_mode        (trig_mode),
    .qual_cnt         (qual_cnt),
    .armed            (armed),
    .set_capture_done (set_capture_done),
    .triggered        (sat_triggered),
    .qualifying       (sat_qualifying),
    .trig_src         (sat_trig_src),
    .trig_count       (sat_trig_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ch_trig = '0; trig_en = '0; trig_mode = 1'b0;
    qual_cnt = '0; armed = 1'b0; set_capture_done = 1'b0;
    #3;
    check("rst_triggered", 32'(triggered), 32'd0);
    check("rst_qualifying", 32'(qualifying), 32'd0);
    check("rst_trig_src", 32'(trig_src), 32'd0);
    check("rst_trig_count", 32'(trig_count), 32'd0);
    #5 rst_n = 1'b1;

    // Unarmed: all channels high but no search.
    trig_en = 5'h1F; ch_trig = 5'h1F; armed = 1'b0;
    step(4);
    check("unarmed_triggered", 32'(triggered), 32'd0);
    check("unarmed_count", 32'(trig_count), 32'd0);

    // AND mode, immediate trigger, sticky.
    trig_mode = 1'b0; qual_cnt = 8'd0; armed = 1'b1; ch_trig = 5'h1E;
    step(2);
    check("and_partial", 32'(triggered), 32'd0);
    ch_trig = 5'h1F;
    step(1);
    check("and_triggered", 32'(triggered), 32'd1);
    check("and_src", 32'(trig_src), 32'h1F);
    check("and_count", 32'(trig_count), 32'd1);
    check("sat_count_1", 32'(sat_trig_count), 32'd1);
    armed = 1'b0; ch_trig = 5'h00;
    step(3);
    check("sticky", 32'(triggered), 32'd1);
    set_capture_done = 1'b1;
    step(1);
    set_capture_done = 1'b0;
    check("cleared", 32'(triggered), 32'd0);
    check("cleared_count", 32'(trig_count), 32'd1);

    // OR mode with a single-channel mask.
    trig_mode = 1'b1; trig_en = 5'h04; ch_trig = 5'h1B; armed = 1'b1;
    step(3);
    check("or_masked", 32'(triggered), 32'd0);
    ch_trig = 5'h04;
    step(1);
    check("or_triggered", 32'(triggered), 32'd1);
    check("or_src", 32'(trig_src), 32'h04);
    check("or_count", 32'(trig_count), 32'd2);
    armed = 1'b0; ch_trig = 5'h00; set_capture_done = 1'b1;
    step(1);
    set_capture_done = 1'b0;
    check("src_kept", 32'(trig_src), 32'h04);

    // Empty mask in AND mode never triggers.
    trig_mode = 1'b0; trig_en = 5'h00; ch_trig = 5'h1F; armed = 1'b1;
    step(4);
    check("empty_mask_trig", 32'(triggered), 32'd0);
    check("empty_mask_qual", 32'(qualifying), 32'd0);

    // Qualification: 3 highs then a low restarts, then 4 highs trigger.
    trig_en = 5'h1F; qual_cnt = 8'd3;
    step(1);
    check("q_first", 32'(qualifying), 32'd1);
    step(2);
    check("q_third", 32'(qualifying), 32'd1);
    check("q_third_trig", 32'(triggered), 32'd0);
    ch_trig = 5'h00;
    step(1);
    check("q_drop", 32'(qualifying), 32'd0);
    check("q_drop_trig", 32'(triggered), 32'd0);
    ch_trig = 5'h1F;
    step(1);
    check("q2_1", 32'(qualifying), 32'd1);
    step(2);
    check("q2_3", 32'(qualifying), 32'd1);
    check("q2_3_trig", 32'(triggered), 32'd0);
    step(1);
    check("q2_trig", 32'(triggered), 32'd1);
    check("q2_qual_low", 32'(qualifying), 32'd0);
    check("q2_count", 32'(trig_count), 32'd3);
    armed = 1'b0; set_capture_done = 1'b1;
    step(1);

    // Capture-done wins over a same-cycle hit; re-acquire on the next edge.
    qual_cnt = 8'd0; armed = 1'b1; set_capture_done = 1'b1;
    step(1);
    check("prio_trig", 32'(triggered), 32'd0);
    check("prio_count", 32'(trig_count), 32'd3);
    set_capture_done = 1'b0;
    step(1);
    check("reacq_trig", 32'(triggered), 32'd1);
    check("reacq_count", 32'(trig_count), 32'd4);
    set_capture_done = 1'b1;
    step(1);
    set_capture_done = 1'b0;
    step(1);
    check("fifth_count", 32'(trig_count), 32'd5);
    check("sat_count", 32'(sat_trig_count), 32'd3);
    armed = 1'b0; set_capture_done = 1'b1;
    step(1);
    set_capture_done = 1'b0;

    // Async reset in the middle of qualification.
    qual_cnt = 8'd3; armed = 1'b1; ch_trig = 5'h1F;
    step(2);
    check("pre_rst_qual", 32'(qualifying), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_qual", 32'(qualifying), 32'd0);
    check("arst_trig", 32'(triggered), 32'd0);
    check("arst_src", 32'(trig_src), 32'd0);
    check("arst_count", 32'(trig_count), 32'd0);
    check("arst_sat_count", 32'(sat_trig_count), 32'd0);
    #1 rst_n = 1'b1;
    step(1);
    check("post_rst_qual", 32'(qualifying), 32'd1);
    check("post_rst_trig", 32'(triggered), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multi_trigger_logic.md
# multi_trigger_logic

Parametrised trigger qualifier that succeeds the fixed five-channel AND trigger in the capture path. It combines `NUM_CH` per-channel trigger flags using an enable mask and a selectable AND/OR mode. It requires the combined condition to hold for a programmable number of consecutive cycles, then asserts a sticky `triggered` flag for the capture controller. It also latches which channels caused the trigger and keeps a saturating count of trigger events.

## Interface
- `NUM_CH`, default 5: number of trigger channels (≥1).
- `QUAL_W`, default 8: width of the qualification length field.
- `CNT_W`, default 16: width of the trigger event counter.

- `clk`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ch_trig`  in  NUM_CH  per-channel trigger flags; bit 0 = CH1.
- `trig_en`  in  NUM_CH  per-channel enable mask; 1 = channel participates.
- `trig_mode`  in  1  0 = AND of enabled channels, 1 = OR of enabled channels.
- `qual_cnt`  in  QUAL_W  extra consecutive cycles the condition must hold; 0 = immediate.
- `armed`  in  1  trigger search enabled.
- `set_capture_done`  in  1  capture complete; clears trigger, returns to idle.
- `triggered`  out  1  sticky trigger flag, registered.
- `qualifying`  out  1  high while in QUAL state, registered.
- `trig_src`  out  NUM_CH  `ch_trig & trig_en` latched on the trigger edge.
- `trig_count`  out  CNT_W  number of triggers since reset, saturating.

## Operation
- Combined condition `cond`, combinational:
  - AND mode: every enabled channel is high (`&(ch_trig | ~trig_en)`) and at least one channel is enabled (`|trig_en`).
  - OR mode: `|(ch_trig & trig_en)`.
  - `trig_en == 0` always gives `cond = 0`.
- `hit = armed & cond`.
- FSM states are IDLE, QUAL, TRIGD. The internal counter `qcnt` is `QUAL_W` bits wide.
- IDLE:
  - `hit` and `qual_cnt == 0` → TRIGD.
  - `hit` and `qual_cnt != 0` → QUAL with `qcnt = 1`.
  - Otherwise stay in IDLE with `qcnt = 0`.
- QUAL:
  - `!hit` → IDLE with `qcnt = 0`.
  - `hit` and `qcnt >= qual_cnt` → TRIGD.
  - Otherwise `qcnt` increments.
  - Using `>=` means lowering `qual_cnt` mid-qualification takes effect on the next edge.
- TRIGD:
  - Hold. Deasserting `armed` and dropping `cond` have no effect.
  - Leave only on `set_capture_done` → IDLE.
- `set_capture_done` has priority in every state: next state is IDLE, `qcnt = 0`, and no trigger is recorded that cycle even if `hit`.
- On each entry to TRIGD:
  - `trig_src` loads `ch_trig & trig_en` as sampled on that edge.
  - `trig_count` increments, holding at `2^CNT_W - 1`.
- `trig_src` holds its value until the next trigger. It is not cleared by `set_capture_done`.
- `trig_en`, `trig_mode` and `qual_cnt` are sampled every cycle with no shadowing.
- Total consecutive high samples required is `qual_cnt + 1`.

## Timing
- Reset values (async, immediate): state IDLE, `qcnt = 0`, `triggered = 0`, `qualifying = 0`, `trig_src = 0`, `trig_count = 0`.
- Latency, `qual_cnt = 0`: `hit` sampled at edge k → `triggered = 1` after edge k.
- Latency, `qual_cnt = N`: `hit` sampled high at edges k … k+N → `triggered = 1` after edge k+N.
  - `qualifying` is high after edges k … k+N-1.
  - A single low sample restarts the count.
- `triggered` falls after the edge that samples `set_capture_done = 1`. A trigger can be re-acquired at the earliest on the following edge.
- `triggered` and `qualifying` are never high together.
- Reset asserted mid-QUAL or mid-TRIGD returns everything to reset values asynchronously. After release, the first edge behaves as IDLE.

## Test plan
- **Reset / unarmed:** `NUM_CH = 5`, `trig_en = 5'h1F`, `ch_trig = 5'h1F`, `armed = 0` for 4 cycles → `triggered = 0`, `trig_count = 0`.
- **AND mode, immediate trigger, sticky:**
  - Stimulus: `trig_mode = 0`, `qual_cnt = 0`, `armed = 1`, `ch_trig = 5'h1E` for 2 cycles, then `5'h1F`.
  - Required: `triggered = 1` one edge later, `trig_src = 5'h1F`, `trig_count = 1`.
  - Then `armed = 0`, `ch_trig = 0` → `triggered` stays 1.
  - Then `set_capture_done = 1` → `triggered = 0` after one edge.
- **OR mode with mask:**
  - Stimulus: `trig_mode = 1`, `trig_en = 5'h04`, `ch_trig = 5'h1B` → no trigger.
  - Then `ch_trig = 5'h04` → `triggered = 1`, `trig_src = 5'h04`.
  - Separately, `trig_en = 0` in AND mode → never triggers.
- **Qualification:**
  - `qual_cnt = 3`, `hit` high for 3 cycles then low for 1 → `qualifying` drops, no trigger.
  - `hit` then high for 4 cycles → `triggered = 1` after the 4th edge, `qualifying` high for the preceding 3 cycles.
- **Priority:** `set_capture_done = 1` in the same cycle as first `hit` with `qual_cnt = 0` → `triggered` stays 0, `trig_count` unchanged.
- **Saturation / async reset:**
  - `CNT_W = 2`, run 5 trigger/clear cycles → `trig_count = 3`.
  - Assert `rst_n = 0` mid-QUAL between edges → all outputs 0 immediately.
